// File: rtl/mod_pipe_pkg.sv
// Shared pipeline bundle types, opcode constants and memory-stage FSM states.
// Imported by the execute, memory and writeback stages.
package mod_pipe_pkg;

    localparam logic [7:0] OP_LOAD    = 8'd139;
    localparam logic [7:0] OP_STORE   = 8'd137;
    localparam logic [7:0] OP_LEA     = 8'd141;
    localparam logic [7:0] OP_RETQ    = 8'd195;
    localparam logic [7:0] OP_CALL    = 8'd232;
    localparam logic [7:0] OP_GRP5    = 8'd255;
    localparam logic [7:0] OP_PUSH_LO = 8'd80;
    localparam logic [7:0] OP_PUSH_HI = 8'd87;
    localparam logic [7:0] OP_POP_LO  = 8'd88;
    localparam logic [7:0] OP_POP_HI  = 8'd95;

    typedef struct packed {
        logic [63:0] pc_contents;
        logic [63:0] alu_result;
        logic [63:0] alu_ext_result;
        logic [63:0] ea;
        logic [63:0] store_data;
        logic [7:0]  ctl_opcode;
        logic [7:0]  twob_opcode;
        logic [7:0]  ctl_regByte;
        logic [7:0]  ctl_rmByte;
        logic        sim_end;
        logic [1:0]  mod;
    } mem_ex_t;

    typedef struct packed {
        logic [63:0] pc_contents;
        logic [63:0] alu_result;
        logic [63:0] alu_ext_result;
        logic [7:0]  ctl_opcode;
        logic [7:0]  twob_opcode;
        logic [7:0]  ctl_regByte;
        logic [7:0]  ctl_rmByte;
        logic        sim_end;
        logic [1:0]  mod;
    } ex_wb_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_WAIT_R = 2'd2,
        ST_RETIRE = 2'd3
    } mem_state_e;

    // Writeback carries everything except the memory operands.
    function automatic ex_wb_t to_exwb(input mem_ex_t m);
        ex_wb_t w;
        w.pc_contents    = m.pc_contents;
        w.alu_result     = m.alu_result;
        w.alu_ext_result = m.alu_ext_result;
        w.ctl_opcode     = m.ctl_opcode;
        w.twob_opcode    = m.twob_opcode;
        w.ctl_regByte    = m.ctl_regByte;
        w.ctl_rmByte     = m.ctl_rmByte;
        w.sim_end        = m.sim_end;
        w.mod            = m.mod;
        return w;
    endfunction

endpackage

// File: rtl/mod_memory_stage_classify.sv
// Decides whether an instruction needs a data-memory load, a store, or nothing.
// Register-direct forms (mod == 3) of MOV never touch memory.
module mem_op_classify
    import mod_pipe_pkg::*;
(
    input  logic [7:0] ctl_opcode,
    input  logic [1:0] mod,
    output logic       is_load,
    output logic       is_store
);

    // Opcode decode into the two memory access kinds.
    always_comb begin
        is_load  = ((ctl_opcode == OP_LOAD) && (mod != 2'd3))
                || ((ctl_opcode >= OP_POP_LO) && (ctl_opcode <= OP_POP_HI))
                || (ctl_opcode == OP_RETQ);
        is_store = ((ctl_opcode == OP_STORE) && (mod != 2'd3))
                || ((ctl_opcode >= OP_PUSH_LO) && (ctl_opcode <= OP_PUSH_HI))
                || (ctl_opcode == OP_CALL)
                || (ctl_opcode == OP_GRP5);
    end

endmodule

// File: rtl/mod_memory_stage.sv
// Memory pipeline stage: one load/store per instruction over a req/gnt/rvalid bus,
// result registered into the writeback bundle with a one-cycle can_writeback pulse.
module mod_memory_stage
    import mod_pipe_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              memex_valid,
    input  mem_ex_t           memex,
    output logic              mem_ready,
    input  logic              flush,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [0:ADDR_W-1] dmem_addr,
    output logic [0:DATA_W-1] dmem_wdata,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    input  logic [0:DATA_W-1] dmem_rdata,
    output ex_wb_t            exwb,
    output logic              can_writeback,
    output logic              store_memstage_active,
    output logic [0:1]        dep_memwb
);

    mem_state_e state_r, state_s;
    ex_wb_t     held_r, src_s, exwb_s;
    logic       kill_r, kill_s;
    logic       accept_s;
    logic       is_load_s, is_store_s;

    // In IDLE the incoming bundle is classified so the capture cycle can pick REQ or RETIRE.
    always_comb begin
        accept_s = (state_r == ST_IDLE) && memex_valid && !flush;
        if (state_r == ST_IDLE) begin
            src_s = to_exwb(memex);
        end else begin
            src_s = held_r;
        end
        exwb_s = src_s;
        if (state_r == ST_WAIT_R) begin
            exwb_s.alu_result = 64'(dmem_rdata);
        end else begin
            exwb_s.alu_result = src_s.alu_result;
        end
    end

    mem_op_classify u_classify (
        .ctl_opcode (src_s.ctl_opcode),
        .mod        (src_s.mod),
        .is_load    (is_load_s),
        .is_store   (is_store_s)
    );

    // Next-state logic; a flushed read still drains its rvalid before returning to IDLE.
    always_comb begin
        state_s = state_r;
        kill_s  = kill_r;
        case (state_r)
            ST_IDLE: begin
                kill_s = 1'b0;
                if (accept_s) begin
                    if (is_load_s || is_store_s) begin
                        state_s = ST_REQ;
                    end else begin
                        state_s = ST_RETIRE;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (dmem_gnt) begin
                    if (is_store_s) begin
                        state_s = ST_RETIRE;
                    end else begin
                        state_s = ST_WAIT_R;
                    end
                end else if (flush) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_WAIT_R: begin
                if (dmem_rvalid) begin
                    kill_s = 1'b0;
                    if (kill_r || flush) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_RETIRE;
                    end
                end else begin
                    kill_s  = kill_r || flush;
                    state_s = ST_WAIT_R;
                end
            end
            ST_RETIRE: begin
                state_s = ST_IDLE;
            end
            default: begin
                kill_s  = 1'b0;
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, captured bundle and all outputs registered from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r               <= ST_IDLE;
            kill_r                <= 1'b0;
            held_r                <= '0;
            mem_ready             <= 1'b0;
            dmem_req              <= 1'b0;
            dmem_we               <= 1'b0;
            dmem_addr             <= '0;
            dmem_wdata            <= '0;
            exwb                  <= '0;
            can_writeback         <= 1'b0;
            store_memstage_active <= 1'b0;
            dep_memwb             <= 2'b00;
        end else begin
            state_r               <= state_s;
            kill_r                <= kill_s;
            mem_ready             <= (state_s == ST_IDLE);
            dmem_req              <= (state_s == ST_REQ);
            can_writeback         <= (state_s == ST_RETIRE);
            store_memstage_active <= (state_s == ST_RETIRE) && is_store_s;
            dep_memwb             <= (is_load_s && (state_s != ST_IDLE)) ? 2'b01 : 2'b00;
            if (accept_s) begin
                held_r     <= src_s;
                dmem_we    <= is_store_s;
                dmem_addr  <= ADDR_W'(memex.ea);
                dmem_wdata <= DATA_W'(memex.store_data);
            end
            if (state_s == ST_RETIRE) begin
                exwb <= exwb_s;
            end
        end
    end

endmodule

// File: tb/tb_mod_memory_stage.sv
// Directed self-checking bench for mod_memory_stage: inputs driven and outputs
// sampled on the falling clock edge, expected values written by hand.
module tb_mod_memory_stage;
    import mod_pipe_pkg::*;

    logic        clk;
    logic        reset;
    logic        memex_valid;
    mem_ex_t     memex;
    logic        mem_ready;
    logic        flush;
    logic        dmem_req;
    logic        dmem_we;
    logic [0:63] dmem_addr;
    logic [0:63] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [0:63] dmem_rdata;
    ex_wb_t      exwb;
    logic        can_writeback;
    logic        store_memstage_active;
    logic [0:1]  dep_memwb;

    int total;
    int bad;

    mod_memory_stage #(.ADDR_W(64), .DATA_W(64)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .memex_valid           (memex_valid),
        .memex                 (memex),
        .mem_ready             (mem_ready),
        .flush                 (flush),
        .dmem_req              (dmem_req),
        .dmem_we               (dmem_we),
        .dmem_addr             (dmem_addr),
        .dmem_wdata            (dmem_wdata),
        .dmem_gnt              (dmem_gnt),
        .dmem_rvalid           (dmem_rvalid),
        .dmem_rdata            (dmem_rdata),
        .exwb                  (exwb),
        .can_writeback         (can_writeback),
        .store_memstage_active (store_memstage_active),
        .dep_memwb             (dep_memwb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic mem_ex_t make_op(input logic [7:0] op, input logic [1:0] md,
                                        input logic [63:0] ea, input logic [63:0] sd,
                                        input logic [63:0] res);
        mem_ex_t m;
        m = '0;
        m.ctl_opcode = op;
        m.mod        = md;
        m.ea         = ea;
        m.store_data = sd;
        m.alu_result = res;
        return m;
    endfunction

    task automatic issue(input mem_ex_t m);
        @(negedge clk);
        memex       = m;
        memex_valid = 1'b1;
        @(negedge clk);
        memex_valid = 1'b0;
    endtask

    task automatic test_reset;
        #3;
        total++; if (mem_ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got %0b want 0", mem_ready); end
        total++; if (dmem_req !== 1'b0) begin bad++; $display("FAIL rst_req: got %0b want 0", dmem_req); end
        total++; if (can_writeback !== 1'b0) begin bad++; $display("FAIL rst_cwb: got %0b want 0", can_writeback); end
        total++; if (exwb !== '0) begin bad++; $display("FAIL rst_exwb: got %h want 0", exwb); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        total++; if (mem_ready !== 1'b1) begin bad++; $display("FAIL rst_ready_rel: got %0b want 1", mem_ready); end
        total++; if (dep_memwb !== 2'b00) begin bad++; $display("FAIL rst_dep: got %b want 00", dep_memwb); end
    endtask

    task automatic test_none;
        mem_ex_t m;
        m = make_op(8'd1, 2'd0, 64'h0, 64'h0, 64'h5);
        m.sim_end     = 1'b1;
        m.pc_contents = 64'h400;
        issue(m);
        total++; if (can_writeback !== 1'b1) begin bad++; $display("FAIL none_cwb: got %0b want 1", can_writeback); end
        total++; if (exwb.alu_result !== 64'h5) begin bad++; $display("FAIL none_res: got %h want 5", exwb.alu_result); end
        total++; if (exwb.sim_end !== 1'b1) begin bad++; $display("FAIL none_simend: got %0b want 1", exwb.sim_end); end
        total++; if (exwb.pc_contents !== 64'h400) begin bad++; $display("FAIL none_pc: got %h want 400", exwb.pc_contents); end
        total++; if (store_memstage_active !== 1'b0) begin bad++; $display("FAIL none_st: got %0b want 0", store_memstage_active); end
        total++; if (mem_ready !== 1'b0) begin bad++; $display("FAIL none_ready: got %0b want 0", mem_ready); end
        @(negedge clk);
        total++; if (can_writeback !== 1'b0) begin bad++; $display("FAIL none_pulse: got %0b want 0", can_writeback); end
        total++; if (mem_ready !== 1'b1) begin bad++; $display("FAIL none_ready2: got %0b want 1", mem_ready); end
    endtask

    task automatic test_classify;
        logic [7:0] ops [3];
        logic [1:0] mods [3];
        ops[0] = 8'd141; mods[0] = 2'd0;
        ops[1] = 8'd139; mods[1] = 2'd3;
        ops[2] = 8'd137; mods[2] = 2'd3;
        for (int i = 0; i < 3; i++) begin
            issue(make_op(ops[i], mods[i], 64'h9000, 64'h0, 64'(i + 16)));
            total++; if (can_writeback !== 1'b1 || dmem_req !== 1'b0) begin bad++; $display("FAIL cls_none[%0d]: got cwb=%0b req=%0b want cwb=1 req=0", i, can_writeback, dmem_req); end
            total++; if (exwb.alu_result !== 64'(i + 16)) begin bad++; $display("FAIL cls_res[%0d]: got %h want %h", i, exwb.alu_result, i + 16); end
            @(negedge clk);
        end
    endtask

    task automatic test_load;
        issue(make_op(8'd139, 2'd0, 64'h1000, 64'h0, 64'h77));
        total++; if (dmem_req !== 1'b1 || dmem_we !== 1'b0) begin bad++; $display("FAIL ld_req: got req=%0b we=%0b want 1 0", dmem_req, dmem_we); end
        total++; if (dmem_addr !== 64'h1000) begin bad++; $display("FAIL ld_addr: got %h want 1000", dmem_addr); end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            total++; if (dmem_req !== 1'b1 || dep_memwb !== 2'b01) begin bad++; $display("FAIL ld_hold[%0d]: got req=%0b dep=%b want 1 01", i, dmem_req, dep_memwb); end
        end
        dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0;
        total++; if (dmem_req !== 1'b0 || mem_ready !== 1'b0) begin bad++; $display("FAIL ld_gnt: got req=%0b ready=%0b want 0 0", dmem_req, mem_ready); end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            total++; if (can_writeback !== 1'b0 || dep_memwb !== 2'b01) begin bad++; $display("FAIL ld_wait[%0d]: got cwb=%0b dep=%b want 0 01", i, can_writeback, dep_memwb); end
        end
        dmem_rvalid = 1'b1;
        dmem_rdata  = 64'hDEAD_BEEF;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        total++; if (can_writeback !== 1'b1) begin bad++; $display("FAIL ld_cwb: got %0b want 1", can_writeback); end
        total++; if (exwb.alu_result !== 64'hDEAD_BEEF) begin bad++; $display("FAIL ld_data: got %h want deadbeef", exwb.alu_result); end
        total++; if (dep_memwb !== 2'b01 || mem_ready !== 1'b0) begin bad++; $display("FAIL ld_retire: got dep=%b ready=%0b want 01 0", dep_memwb, mem_ready); end
        @(negedge clk);
        total++; if (dep_memwb !== 2'b00 || mem_ready !== 1'b1) begin bad++; $display("FAIL ld_after: got dep=%b ready=%0b want 00 1", dep_memwb, mem_ready); end
    endtask

    task automatic test_push;
        issue(make_op(8'd82, 2'd3, 64'h7FF8, 64'h42, 64'h7FF8));
        dmem_gnt = 1'b1;
        total++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1) begin bad++; $display("FAIL push_req: got req=%0b we=%0b want 1 1", dmem_req, dmem_we); end
        total++; if (dmem_addr !== 64'h7FF8 || dmem_wdata !== 64'h42) begin bad++; $display("FAIL push_bus: got addr=%h wdata=%h want 7ff8 42", dmem_addr, dmem_wdata); end
        @(negedge clk);
        dmem_gnt = 1'b0;
        total++; if (can_writeback !== 1'b1 || store_memstage_active !== 1'b1) begin bad++; $display("FAIL push_ret: got cwb=%0b st=%0b want 1 1", can_writeback, store_memstage_active); end
        total++; if (dep_memwb !== 2'b00 || exwb.alu_result !== 64'h7FF8) begin bad++; $display("FAIL push_exwb: got dep=%b res=%h want 00 7ff8", dep_memwb, exwb.alu_result); end
        @(negedge clk);
        total++; if (store_memstage_active !== 1'b0 || can_writeback !== 1'b0) begin bad++; $display("FAIL push_after: got st=%0b cwb=%0b want 0 0", store_memstage_active, can_writeback); end
    endtask

    task automatic test_flush_wait_r;
        issue(make_op(8'd88, 2'd0, 64'h2000, 64'h0, 64'h0));
        dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0;
        flush    = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        total++; if (can_writeback !== 1'b0 || mem_ready !== 1'b0) begin bad++; $display("FAIL fw_wait: got cwb=%0b ready=%0b want 0 0", can_writeback, mem_ready); end
        @(negedge clk);
        dmem_rvalid = 1'b1;
        dmem_rdata  = 64'h1234;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        total++; if (can_writeback !== 1'b0) begin bad++; $display("FAIL fw_noret: got %0b want 0", can_writeback); end
        total++; if (mem_ready !== 1'b1 || dep_memwb !== 2'b00) begin bad++; $display("FAIL fw_idle: got ready=%0b dep=%b want 1 00", mem_ready, dep_memwb); end
        memex       = make_op(8'd1, 2'd0, 64'h0, 64'h0, 64'h9);
        memex_valid = 1'b1;
        @(negedge clk);
        memex_valid = 1'b0;
        total++; if (can_writeback !== 1'b1 || exwb.alu_result !== 64'h9) begin bad++; $display("FAIL fw_next: got cwb=%0b res=%h want 1 9", can_writeback, exwb.alu_result); end
        @(negedge clk);
    endtask

    task automatic test_flush_req;
        issue(make_op(8'd139, 2'd1, 64'h3000, 64'h0, 64'h0));
        total++; if (dmem_req !== 1'b1) begin bad++; $display("FAIL fr_req: got %0b want 1", dmem_req); end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        total++; if (dmem_req !== 1'b0 || mem_ready !== 1'b1) begin bad++; $display("FAIL fr_drop: got req=%0b ready=%0b want 0 1", dmem_req, mem_ready); end
        total++; if (can_writeback !== 1'b0) begin bad++; $display("FAIL fr_noret: got %0b want 0", can_writeback); end
        @(negedge clk);
        total++; if (can_writeback !== 1'b0 || dmem_req !== 1'b0) begin bad++; $display("FAIL fr_quiet: got cwb=%0b req=%0b want 0 0", can_writeback, dmem_req); end
    endtask

    task automatic test_flush_gnt;
        issue(make_op(8'd137, 2'd0, 64'h40, 64'hAA, 64'h40));
        dmem_gnt = 1'b1;
        flush    = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0;
        flush    = 1'b0;
        total++; if (can_writeback !== 1'b1 || store_memstage_active !== 1'b1) begin bad++; $display("FAIL fg_ret: got cwb=%0b st=%0b want 1 1", can_writeback, store_memstage_active); end
        @(negedge clk);
        total++; if (mem_ready !== 1'b1) begin bad++; $display("FAIL fg_ready: got %0b want 1", mem_ready); end
    endtask

    task automatic test_reset_mid_req;
        issue(make_op(8'd195, 2'd0, 64'h5000, 64'h0, 64'h0));
        total++; if (dmem_req !== 1'b1) begin bad++; $display("FAIL rm_req: got %0b want 1", dmem_req); end
        #2;
        reset = 1'b1;
        #1;
        total++; if (dmem_req !== 1'b0 || mem_ready !== 1'b0) begin bad++; $display("FAIL rm_async: got req=%0b ready=%0b want 0 0", dmem_req, mem_ready); end
        total++; if (can_writeback !== 1'b0 || dep_memwb !== 2'b00) begin bad++; $display("FAIL rm_outs: got cwb=%0b dep=%b want 0 00", can_writeback, dep_memwb); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        total++; if (mem_ready !== 1'b1) begin bad++; $display("FAIL rm_ready: got %0b want 1", mem_ready); end
        memex       = make_op(8'd2, 2'd0, 64'h0, 64'h0, 64'h55);
        memex_valid = 1'b1;
        @(negedge clk);
        memex_valid = 1'b0;
        total++; if (can_writeback !== 1'b1 || exwb.alu_result !== 64'h55) begin bad++; $display("FAIL rm_none: got cwb=%0b res=%h want 1 55", can_writeback, exwb.alu_result); end
        @(negedge clk);
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        reset       = 1'b1;
        memex_valid = 1'b0;
        memex       = '0;
        flush       = 1'b0;
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata  = '0;
        test_reset();
        test_none();
        test_classify();
        test_load();
        test_push();
        test_flush_wait_r();
        test_flush_req();
        test_flush_gnt();
        test_reset_mid_req();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mod_memory_stage.md
Name: mod_memory_stage

Overview:
- Pipeline stage between execute and writeback.
- Takes the MEM_EX bundle from execute and performs the single data-memory access the instruction needs: a load, a store or nothing. The memory is reached over a req/gnt/rvalid bus.
- Registers the result into the EX_WB bundle and pulses can_writeback for exactly one cycle per retired instruction.
- Holds off execute while a memory access is in flight.

Parameters:
- ADDR_W, 64, data-memory address width.
- DATA_W, 64, data width; must equal the EX_WB alu_result width.

Ports:
- clk  input  1  pipeline clock.
- reset  input  1  asynchronous, active-high reset.
- memex_valid  input  1  memex holds a new instruction this cycle.
- memex  input  MEM_EX  execute result bundle: pc_contents, alu_result, alu_ext_result, ea, store_data, ctl_opcode, twob_opcode, ctl_regByte, ctl_rmByte, sim_end, mod.
- mem_ready  output  1  stage can accept memex this cycle.
- flush  input  1  kill the uncommitted instruction (branch redirect).
- dmem_req  output  1  bus request.
- dmem_we  output  1  1 = write.
- dmem_addr  output  [0:ADDR_W-1]  byte address.
- dmem_wdata  output  [0:DATA_W-1]  write data.
- dmem_gnt  input  1  request accepted this cycle.
- dmem_rvalid  input  1  read data valid.
- dmem_rdata  input  [0:DATA_W-1]  read data.
- exwb  output  EX_WB  registered bundle to writeback.
- can_writeback  output  1  exwb valid, one-cycle pulse.
- store_memstage_active  output  1  the retiring instruction performed a store.
- dep_memwb  output  [0:1]  load-use hazard flag to decode: 2'b01 while a load destination is pending, else 0.

Behaviour:
- Reset: asynchronous, active-high. All outputs 0, exwb all-zero, FSM in IDLE, mem_ready=0 while reset is asserted and 1 in the first cycle after release.
- Classification, from the registered bundle:
  - LOAD: ctl_opcode 139 with mod!=3; 88..95 (POP); 195 (RETQ).
  - STORE: 137 with mod!=3; 80..87 (PUSH); 232; 255.
  - NONE: everything else, including 141 when twob_opcode=0.
- Address selection:
  - LOAD/STORE use ea.
  - PUSH/CALL use ea (execute supplies rsp-8).
- Store data: dmem_wdata = store_data.
- FSM states:
  - IDLE: mem_ready=1. When memex_valid && !flush, capture memex. NONE → RETIRE; LOAD/STORE → REQ.
  - REQ: dmem_req=1, with dmem_addr, dmem_we and dmem_wdata held stable until dmem_gnt. On gnt: store → RETIRE (posted write); load → WAIT_R.
  - WAIT_R: wait for dmem_rvalid, capture dmem_rdata into the alu_result field → RETIRE.
  - RETIRE: drive exwb from the captured bundle (loads substitute read data), assert can_writeback=1 for one cycle, then go to IDLE.
  - mem_ready=0 in REQ, WAIT_R and RETIRE.
- Latency from memex capture to can_writeback:
  - NONE: 1 cycle.
  - Store: 1 + gnt wait + 1.
  - Load: 1 + gnt wait + rvalid wait + 1.
  - gnt and rvalid in the same cycle are not legal; rvalid arrives at least 1 cycle after gnt.
- store_memstage_active = 1 exactly in the RETIRE cycle of a STORE, else 0.
- dep_memwb = 2'b01 from capture of a LOAD until the end of its RETIRE cycle.
- sim_end is carried unchanged into exwb. The stage never calls $finish.
- Flush handling:
  - In IDLE: ignore memex that cycle.
  - In REQ before gnt: drop dmem_req next cycle, go to IDLE, no retire.
  - In REQ on the same cycle as gnt: the access is committed and retires normally.
  - In WAIT_R: set a kill bit, wait for rvalid, then go to IDLE without retiring (no orphaned rvalid).
  - In RETIRE: ignored; the instruction is committed.
- Reset mid-access: the FSM returns to IDLE immediately and dmem_req drops asynchronously. The bus must tolerate an abandoned request.
- exwb holds its last value outside RETIRE. Consumers must qualify exwb with can_writeback.

Decomposition:
- Package mod_pipe_pkg holds the MEM_EX and EX_WB typedefs (shared with the execute and writeback stages), the opcode constants (OP_LOAD=139, OP_STORE=137, OP_LEA=141, OP_RETQ=195, OP_CALL=232, OP_GRP5=255, OP_PUSH_LO=80, OP_POP_LO=88, OP_POP_HI=95) and the FSM state enum.
- Sub-module mem_op_classify: purely combinational, MEM_EX → {is_load, is_store}.

Test Plan:
- NONE op (ctl_opcode=1, alu_result=64'h5): can_writeback one cycle after capture, exwb.alu_result=5, store_memstage_active=0.
- Load (139, mod=0, ea=64'h1000), gnt after 2 cycles, rvalid 3 cycles after gnt with rdata=64'hDEAD_BEEF: exwb.alu_result=DEAD_BEEF, dep_memwb=01 throughout, mem_ready=0 until after RETIRE.
- PUSH (opcode 82, ea=64'h7FF8, store_data=64'h42), gnt immediately: dmem_we=1, addr=7FF8, wdata=42; RETIRE with store_memstage_active=1 two cycles after capture.
- Flush in WAIT_R of a load, rvalid 2 cycles later: no can_writeback; next memex accepted in the cycle after rvalid.
- Flush in REQ before gnt: dmem_req deasserts next cycle, no bus access, no retire. Flush in the same cycle as gnt: the instruction retires.
- Reset asserted mid-REQ: dmem_req, can_writeback and mem_ready go to 0 without waiting for a clock edge; after release, a NONE op retires normally.
